// File: rtl/sram_ctrl_pkg.sv
// Shared size codes, controller state encoding and lane count for the SRAM port controller.
package sram_ctrl_pkg;

   localparam int LANES = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ACCESS  = 2'b01,
      CAPTURE = 2'b10,
      ERROR   = 2'b11
   } state_t;

endpackage

// File: rtl/sram_lane_align.sv
// Combinational byte-lane steering: store data/mask replication and load shift/extend.
module sram_lane_align
   import sram_ctrl_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] wdata,
   output logic [31:0] din,
   output logic [3:0]  wmask,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_unsigned,
   input  logic [31:0] dout,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   assign shifted = dout >> {ld_off, 3'b000};

   // Store: replicate the narrow datum across all lanes, mask selects the target lane(s)
   always_comb begin
      din   = 32'd0;
      wmask = 4'b0000;
      case (st_size)
         SZ_BYTE: begin
            din   = {4{wdata[7:0]}};
            wmask = 4'b0001 << st_off;
         end
         SZ_HALF: begin
            din   = {2{wdata[15:0]}};
            wmask = 4'b0011 << st_off;
         end
         SZ_WORD: begin
            din   = wdata;
            wmask = 4'b1111;
         end
         default: begin
            din   = 32'd0;
            wmask = 4'b0000;
         end
      endcase
   end

   // Load: right-justify the addressed lane(s), then sign- or zero-extend
   always_comb begin
      rdata = 32'd0;
      case (ld_size)
         SZ_BYTE: rdata = ld_unsigned ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: rdata = ld_unsigned ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
         SZ_WORD: rdata = shifted;
         default: rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/sram_port_ctrl.sv
// Load/store request to SRAM RW-port sequencer with a fixed two-cycle response strobe.
// Optional SRAM_CTRL_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of force-aligning.
module sram_port_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic [3:0]            sram_wmask,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   state_t                  state;
   state_t                  nxt_state;
   logic [1:0]              lat_size;
   logic [1:0]              lat_off;
   logic                    lat_unsigned;
   logic                    lat_we;
   logic [1:0]              eff_off;
   logic                    misalign;
   logic                    out_of_range;
   logic                    bad;
   logic                    accept;
   logic [DATA_WIDTH-1:0]   al_din;
   logic [3:0]              al_wmask;
   logic [DATA_WIDTH-1:0]   al_rdata;
   logic                    nxt_csb;
   logic                    nxt_web;
   logic [3:0]              nxt_wmask;
   logic [ADDR_WIDTH-1:0]   nxt_addr;
   logic [DATA_WIDTH-1:0]   nxt_din;
   logic                    nxt_rsp_valid;
   logic [DATA_WIDTH-1:0]   nxt_rsp_rdata;
   logic                    nxt_rsp_err;

   assign req_ready    = (state == IDLE);
   assign accept       = req_valid && req_ready;
   assign out_of_range = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
   assign bad          = (req_size == SZ_ILL) || out_of_range || misalign;

   // Lane offset actually used; misaligned halves/words are pulled down to their natural boundary
   always_comb begin
      eff_off = req_addr[1:0];
      case (req_size)
         SZ_HALF: eff_off = {req_addr[1], 1'b0};
         SZ_WORD: eff_off = 2'b00;
         default: eff_off = req_addr[1:0];
      endcase
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
   end

   sram_lane_align u_align (
      .st_size     (req_size),
      .st_off      (eff_off),
      .wdata       (req_wdata),
      .din         (al_din),
      .wmask       (al_wmask),
      .ld_size     (lat_size),
      .ld_off      (lat_off),
      .ld_unsigned (lat_unsigned),
      .dout        (sram_dout),
      .rdata       (al_rdata)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   // Request attributes held for the load-data capture two cycles later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_size     <= 2'b00;
         lat_off      <= 2'b00;
         lat_unsigned <= 1'b0;
         lat_we       <= 1'b0;
      end else if (accept) begin
         lat_size     <= req_size;
         lat_off      <= eff_off;
         lat_unsigned <= req_unsigned;
         lat_we       <= req_we;
      end
   end

   // Next state plus next values for every registered output
   always_comb begin
      nxt_state     = state;
      nxt_csb       = sram_csb;
      nxt_web       = sram_web;
      nxt_wmask     = sram_wmask;
      nxt_addr      = sram_addr;
      nxt_din       = sram_din;
      nxt_rsp_valid = 1'b0;
      nxt_rsp_rdata = {DATA_WIDTH{1'b0}};
      nxt_rsp_err   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && bad) begin
               nxt_state = ERROR;
            end else if (req_valid) begin
               nxt_state = ACCESS;
               nxt_csb   = 1'b0;
               nxt_web   = ~req_we;
               nxt_wmask = req_we ? al_wmask : 4'b0000;
               nxt_addr  = req_addr[ADDR_WIDTH+1:2];
               nxt_din   = al_din;
            end else begin
               nxt_state = IDLE;
            end
         end
         ACCESS: begin
            nxt_state = CAPTURE;
            nxt_csb   = 1'b1;
            nxt_web   = 1'b1;
            nxt_wmask = 4'b0000;
         end
         CAPTURE: begin
            nxt_state     = IDLE;
            nxt_rsp_valid = 1'b1;
            nxt_rsp_rdata = lat_we ? {DATA_WIDTH{1'b0}} : al_rdata;
         end
         ERROR: begin
            nxt_state     = IDLE;
            nxt_rsp_valid = 1'b1;
            nxt_rsp_err   = 1'b1;
         end
         default: begin
            nxt_state = IDLE;
            nxt_csb   = 1'b1;
            nxt_web   = 1'b1;
            nxt_wmask = 4'b0000;
         end
      endcase
   end

   // Registered SRAM pins and response strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_csb   <= 1'b1;
         sram_web   <= 1'b1;
         sram_wmask <= 4'b0000;
         sram_addr  <= {ADDR_WIDTH{1'b0}};
         sram_din   <= {DATA_WIDTH{1'b0}};
         rsp_valid  <= 1'b0;
         rsp_rdata  <= {DATA_WIDTH{1'b0}};
         rsp_err    <= 1'b0;
      end else begin
         sram_csb   <= nxt_csb;
         sram_web   <= nxt_web;
         sram_wmask <= nxt_wmask;
         sram_addr  <= nxt_addr;
         sram_din   <= nxt_din;
         rsp_valid  <= nxt_rsp_valid;
         rsp_rdata  <= nxt_rsp_rdata;
         rsp_err    <= nxt_rsp_err;
      end
   end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl: inline SRAM model, byte-level reference memory and response scoreboard.
module tb_sram_port_ctrl;

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        sram_csb;
   logic        sram_web;
   logic [3:0]  sram_wmask;
   logic [8:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   sram_port_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .sram_csb(sram_csb), .sram_web(sram_web),
      .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din),
      .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int csb_lows = 0;
   logic [31:0] last_rdata = 32'd0;
   logic        last_err = 1'b0;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t q[$];

   logic [7:0] ref_mem [0:2047];

   // SRAM behavioural model: sample on posedge, act on negedge, dout garbage after 1-unit hold
   logic [31:0] mem [0:511];
   logic        s_rd = 1'b0;
   logic        s_wr = 1'b0;
   logic [8:0]  s_a;
   logic [31:0] s_d;
   logic [3:0]  s_m;

   always @(posedge clk) begin
      s_rd <= !sram_csb && sram_web;
      s_wr <= !sram_csb && !sram_web;
      s_a  <= sram_addr;
      s_d  <= sram_din;
      s_m  <= sram_wmask;
      sram_dout <= #1 32'hA5A5_5A5A;
   end

   always @(negedge clk) begin
      if (s_wr) begin
         for (int i = 0; i < 4; i++)
            if (s_m[i]) mem[s_a][8*i +: 8] <= s_d[8*i +: 8];
      end
      if (s_rd) sram_dout <= mem[s_a];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response scoreboard: every out-of-reset cycle the strobe must match the queue head's due cycle
   always @(negedge clk) begin
      if (!sram_csb) csb_lows <= csb_lows + 1;
      if (!reset) begin
         automatic logic exp_v = (q.size() > 0) && (q[0].due == cyc);
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
         if (exp_v) begin
            chk("rsp_rdata", rsp_rdata, q[0].data);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, q[0].err});
            last_rdata <= rsp_rdata;
            last_err   <= rsp_err;
            void'(q.pop_front());
         end else begin
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
         end
      end
   end

   // Reference model on a byte-addressed memory
   function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic err, output logic [31:0] data,
                                 output logic [3:0] mask, output logic [31:0] din_exp);
      int n;
      int a;
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      err = (size == 2'b11) || (addr >= 32'd2048) ||
            (ALIGN_CHK && (addr % n) != 0);
      data = 32'd0;
      mask = 4'b0000;
      din_exp = 32'd0;
      if (!err) begin
         a = int'(addr) - (int'(addr) % n);
         for (int i = 0; i < n; i++) begin
            if (we) begin
               ref_mem[a+i] = wdata[8*i +: 8];
               mask[(a % 4) + i] = 1'b1;
               din_exp[8*((a % 4) + i) +: 8] = wdata[8*i +: 8];
            end else begin
               data[8*i +: 8] = ref_mem[a+i];
            end
         end
         if (!we && !uns && n < 4 && data[8*n-1])
            for (int i = n; i < 4; i++) data[8*i +: 8] = 8'hFF;
      end
   endfunction

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic hold, output int acc);
      int waited;
      logic e;
      logic [31:0] d;
      logic [3:0] m;
      logic [31:0] de;
      logic [31:0] bm;
      waited = 0;
      @(negedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      while (!req_ready && waited < 20) begin
         @(negedge clk); #1;
         waited++;
      end
      if (!req_ready) begin
         chk("accept_timeout", {31'd0, req_ready}, 32'd1);
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      model(we, size, uns, addr, wdata, e, d, m, de);
      q.push_back('{due: acc + (e ? 1 : 2), data: d, err: e});
      @(posedge clk); #1;
      req_valid = hold;
      req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_size = 2'b11; req_we = ~we;
      if (e) begin
         chk("err_csb", {31'd0, sram_csb}, 32'd1);
      end else begin
         chk("acc_csb", {31'd0, sram_csb}, 32'd0);
         chk("acc_web", {31'd0, sram_web}, {31'd0, ~we});
         chk("acc_addr", {23'd0, sram_addr}, {23'd0, addr[10:2]});
         if (we) begin
            bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
            chk("acc_wmask", {28'd0, sram_wmask}, {28'd0, m});
            chk("acc_din", sram_din & bm, de);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 32'd0);
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int acc;
      int prev;
      int base;
      logic [1:0] sz;
      for (int b = 0; b < 2048; b++) ref_mem[b] = 8'(b * 7 + 3);
      for (int w = 0; w < 512; w++)
         for (int i = 0; i < 4; i++) mem[w][8*i +: 8] <= 8'((4*w + i) * 7 + 3);
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(negedge clk); #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_csb", {31'd0, sram_csb}, 32'd1);
      chk("rst_web", {31'd0, sram_web}, 32'd1);
      chk("rst_wmask", {28'd0, sram_wmask}, 32'd0);
      chk("rst_addr", {23'd0, sram_addr}, 32'd0);
      chk("rst_din", sram_din, 32'd0);
      reset = 1'b0;

      issue(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, acc);
      chk("lit_stw_mask", {28'd0, sram_wmask}, 32'h0000_000F);
      chk("lit_stw_addr", {23'd0, sram_addr}, 32'd4);
      issue(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, 1'b0, acc); drain();
      chk("lit_ldw", last_rdata, 32'hDEADBEEF);

      issue(1'b1, 2'b00, 1'b0, 32'h013, 32'h0000_0080, 1'b0, acc);
      chk("lit_stb_mask", {28'd0, sram_wmask}, 32'h0000_0008);
      issue(1'b0, 2'b00, 1'b0, 32'h013, 32'd0, 1'b0, acc); drain();
      chk("lit_ldb_s", last_rdata, 32'hFFFF_FF80);
      issue(1'b0, 2'b00, 1'b1, 32'h013, 32'd0, 1'b0, acc); drain();
      chk("lit_ldb_u", last_rdata, 32'h0000_0080);
      issue(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, 1'b0, acc); drain();
      chk("lit_ldw2", last_rdata, 32'h80AD_BEEF);

      issue(1'b1, 2'b01, 1'b0, 32'h022, 32'h0000_1234, 1'b0, acc);
      issue(1'b0, 2'b01, 1'b0, 32'h022, 32'd0, 1'b0, acc); drain();
      chk("lit_ldh", last_rdata, 32'h0000_1234);
      issue(1'b0, 2'b10, 1'b0, 32'h020, 32'd0, 1'b0, acc); drain();
      chk("lit_ldw3", last_rdata, 32'h1234_EAE3);

      base = csb_lows;
      issue(1'b0, 2'b10, 1'b0, 32'h800, 32'd0, 1'b0, acc); drain();
      chk("lit_oor_err", {31'd0, last_err}, 32'd1);
      issue(1'b1, 2'b11, 1'b0, 32'h000, 32'h1111_1111, 1'b0, acc); drain();
      chk("lit_ill_err", {31'd0, last_err}, 32'd1);
      chk("err_no_csb", csb_lows, base);

      issue(1'b0, 2'b01, 1'b0, 32'h011, 32'd0, 1'b0, acc); drain();
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      chk("lit_mis_err", {31'd0, last_err}, 32'd1);
`else
      chk("lit_mis_data", last_rdata, 32'hFFFF_BEEF);
`endif

      prev = 0;
      for (int k = 0; k < 8; k++) begin
         sz = 2'(k % 3);
         issue(1'b0, sz, 1'(k % 2), 32'h020 + 32'(4*k) +
               ((sz == 2'b00) ? 32'(k % 4) : (sz == 2'b01) ? 32'(2 * (k % 2)) : 32'd0),
               32'd0, (k < 7), acc);
         if (k > 0) chk("b2b_gap", acc - prev, 32'd3);
         prev = acc;
      end
      drain();

      issue(1'b0, 2'b10, 1'b0, 32'h024, 32'd0, 1'b0, acc);
      q.delete();
      reset = 1'b1;
      #1;
      chk("rst_mid_csb", {31'd0, sram_csb}, 32'd1);
      chk("rst_mid_web", {31'd0, sram_web}, 32'd1);
      chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk); #1;
      reset = 1'b0;
      repeat (4) @(negedge clk); #1;

      issue(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, 1'b0, acc); drain();
      chk("lit_post_rst", last_rdata, 32'h80AD_BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
